// File: rtl/stroke_painter_pkg.sv
// rtl/stroke_painter_pkg.sv - lightboard_pkg: pixel encodings, tag and state enums, default frame size
package lightboard_pkg;

    localparam int H_PIX_DEFAULT = 320;
    localparam int V_PIX_DEFAULT = 240;

    localparam logic [7:0] PIX_YELLOW = 8'hC0;
    localparam logic [7:0] PIX_PINK   = 8'hC1;
    localparam logic [7:0] PIX_GREEN  = 8'hC2;
    localparam logic [7:0] PIX_RED    = 8'hC3;
    localparam logic [7:0] PIX_THRESH = 8'h80;
    localparam logic [7:0] PIX_CROSS  = 8'h40;

    typedef enum logic [1:0] {
        TAG_LUMA   = 2'b00,
        TAG_CROSS  = 2'b01,
        TAG_THRESH = 2'b10,
        TAG_INK    = 2'b11
    } tag_e;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_READ     = 4'd1,
        ST_WAIT     = 4'd2,
        ST_DECIDE   = 4'd3,
        ST_WRITE    = 4'd4,
        ST_VGA_ADDR = 4'd5,
        ST_VGA_GAP  = 4'd6,
        ST_VGA_READ = 4'd7,
        ST_CLEAR    = 4'd8
    } state_e;

    // Ink pixel: tag 11 with the colour index in the low two bits.
    function automatic logic [7:0] ink_pixel(input logic [1:0] color);
        return {TAG_INK, 4'b0000, color};
    endfunction

    // Luma pixel: tag 00 with the 6-bit camera luma.
    function automatic logic [7:0] luma_pixel(input logic [5:0] y);
        return {TAG_LUMA, y};
    endfunction

endpackage

// File: rtl/stroke_painter_if.sv
// rtl/stroke_painter_if.sv - pen, camera pixel, frame BRAM and VGA pacing signals of stroke_painter
interface stroke_painter_if #(
    parameter int ADDR_W = 17
);
    logic [10:0]       x_com_in;
    logic [9:0]        y_com_in;
    logic              com_valid_in;
    logic [10:0]       hcount;
    logic [9:0]        vcount;
    logic              pixel_valid_in;
    logic              pixel_ready_out;
    logic [5:0]        y_pixel;
    logic              threshold_in;
    logic [1:0]        color_select;
    logic              write_erase_select;
    logic              clear_in;
    logic [7:0]        pixel_from_bram;
    logic [ADDR_W-1:0] pixel_addr_forbram;
    logic [7:0]        pixel_for_bram;
    logic              valid_pixel_forbram;
    logic              pixeladdr_forvga_valid;
    logic              pixelread_forvga_valid;
    logic              clear_done_out;

    modport master (
        output x_com_in, y_com_in, com_valid_in,
        output hcount, vcount, pixel_valid_in, y_pixel, threshold_in,
        output color_select, write_erase_select, clear_in, pixel_from_bram,
        input  pixel_ready_out, pixel_addr_forbram, pixel_for_bram, valid_pixel_forbram,
        input  pixeladdr_forvga_valid, pixelread_forvga_valid, clear_done_out
    );

    modport slave (
        input  x_com_in, y_com_in, com_valid_in,
        input  hcount, vcount, pixel_valid_in, y_pixel, threshold_in,
        input  color_select, write_erase_select, clear_in, pixel_from_bram,
        output pixel_ready_out, pixel_addr_forbram, pixel_for_bram, valid_pixel_forbram,
        output pixeladdr_forvga_valid, pixelread_forvga_valid, clear_done_out
    );

endinterface

// File: rtl/stroke_painter_brush_window.sv
// rtl/stroke_painter_brush_window.sv - brush_window: clamped brush bounds, arming flag and in-window test
module brush_window
    import lightboard_pkg::*;
#(
    parameter int H_PIX   = H_PIX_DEFAULT,
    parameter int V_PIX   = V_PIX_DEFAULT,
    parameter int BRUSH_R = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [10:0] i_x_com,
    input  logic [9:0]  i_y_com,
    input  logic        i_com_valid,
    input  logic [10:0] i_hcount,
    input  logic [9:0]  i_vcount,
    output logic        o_in_brush
);

    localparam logic [11:0] LP_R_X  = 12'(BRUSH_R);
    localparam logic [10:0] LP_R_Y  = 11'(BRUSH_R);
    localparam logic [11:0] LP_XMAX = 12'(H_PIX - 1);
    localparam logic [10:0] LP_YMAX = 11'(V_PIX - 1);
    localparam logic [11:0] LP_HPIX = 12'(H_PIX);
    localparam logic [10:0] LP_VPIX = 11'(V_PIX);

    logic [10:0] r_x_lo, r_x_hi;
    logic [9:0]  r_y_lo, r_y_hi;
    logic        r_armed;

    logic [11:0] w_x_ext, w_x_sum, w_x_lo, w_x_hi;
    logic [10:0] w_y_ext, w_y_sum, w_y_lo, w_y_hi;
    logic        w_com_ok;

    // One extra bit so x+R cannot wrap before it is clamped to the frame edge.
    assign w_x_ext  = {1'b0, i_x_com};
    assign w_y_ext  = {1'b0, i_y_com};
    assign w_x_sum  = w_x_ext + LP_R_X;
    assign w_y_sum  = w_y_ext + LP_R_Y;
    assign w_x_lo   = (w_x_ext < LP_R_X) ? 12'd0 : (w_x_ext - LP_R_X);
    assign w_y_lo   = (w_y_ext < LP_R_Y) ? 11'd0 : (w_y_ext - LP_R_Y);
    assign w_x_hi   = (w_x_sum > LP_XMAX) ? LP_XMAX : w_x_sum;
    assign w_y_hi   = (w_y_sum > LP_YMAX) ? LP_YMAX : w_y_sum;
    assign w_com_ok = i_com_valid && (w_x_ext < LP_HPIX) && (w_y_ext < LP_VPIX);

    // Capture bounds from in-frame COM strobes only; the first one arms the brush.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_x_lo  <= '0;
            r_x_hi  <= '0;
            r_y_lo  <= '0;
            r_y_hi  <= '0;
            r_armed <= 1'b0;
        end else if (w_com_ok) begin
            r_x_lo  <= w_x_lo[10:0];
            r_x_hi  <= w_x_hi[10:0];
            r_y_lo  <= w_y_lo[9:0];
            r_y_hi  <= w_y_hi[9:0];
            r_armed <= 1'b1;
        end
    end

    assign o_in_brush = r_armed
                     && (i_hcount >= r_x_lo) && (i_hcount <= r_x_hi)
                     && (i_vcount >= r_y_lo) && (i_vcount <= r_y_hi);

endmodule

// File: rtl/stroke_painter.sv
// rtl/stroke_painter.sv - frame-buffer read-modify-write painter; STROKE_CROSSHAIR_EN enables the crosshair overlay
module stroke_painter
    import lightboard_pkg::*;
#(
    parameter int H_PIX   = H_PIX_DEFAULT,
    parameter int V_PIX   = V_PIX_DEFAULT,
    parameter int BRUSH_R = 1,
    parameter int ADDR_W  = 17
) (
    input  logic             clk_in,
    input  logic             rst_in,
    stroke_painter_if.slave  bus
);

    localparam logic [ADDR_W-1:0] LP_H    = ADDR_W'(H_PIX);
    localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(H_PIX * V_PIX - 1);
    localparam logic [10:0]       LP_HPIX = 11'(H_PIX);
    localparam logic [9:0]        LP_VPIX = 10'(V_PIX);

    state_e            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata;
    logic              r_we;
    logic              r_vga_addr_v;
    logic              r_vga_read_v;
    logic              r_clear_done;
    logic              r_ready;
    logic [5:0]        r_luma;
    logic              r_in_brush;
    logic              r_cross;

    logic              w_in_brush;
    logic              w_cross;
    logic              w_accept;
    logic [ADDR_W-1:0] w_pix_addr;
    tag_e              w_tag;
    logic              w_do_write;
    logic [7:0]        w_wdata;

    brush_window #(
        .H_PIX   (H_PIX),
        .V_PIX   (V_PIX),
        .BRUSH_R (BRUSH_R)
    ) u_brush (
        .i_clk       (clk_in),
        .i_rst       (rst_in),
        .i_x_com     (bus.x_com_in),
        .i_y_com     (bus.y_com_in),
        .i_com_valid (bus.com_valid_in),
        .i_hcount    (bus.hcount),
        .i_vcount    (bus.vcount),
        .o_in_brush  (w_in_brush)
    );

`ifdef STROKE_CROSSHAIR_EN
    assign w_cross = (bus.hcount == bus.x_com_in) || (bus.vcount == bus.y_com_in);
`else
    assign w_cross = 1'b0;
`endif

    assign w_accept   = bus.pixel_valid_in && (bus.hcount < LP_HPIX) && (bus.vcount < LP_VPIX);
    assign w_pix_addr = ADDR_W'(bus.vcount) * LP_H + ADDR_W'(bus.hcount);

    // Decide what replaces the stored pixel; existing ink is only ever removed by the eraser under the brush.
    always_comb begin
        w_tag      = tag_e'(bus.pixel_from_bram[7:6]);
        w_do_write = 1'b1;
        w_wdata    = luma_pixel(r_luma);
        if (!bus.write_erase_select) begin
            if (w_tag == TAG_INK) begin
                w_do_write = 1'b0;
            end else if (r_in_brush) begin
                w_wdata = ink_pixel(bus.color_select);
            end else if (bus.threshold_in) begin
                w_wdata = PIX_THRESH;
            end else if (r_cross) begin
                w_wdata = PIX_CROSS;
            end
        end else if ((w_tag == TAG_INK) && !r_in_brush) begin
            w_do_write = 1'b0;
        end
    end

    // Sequencer: fixed 8-cycle pixel slot or full-frame clear sweep, all outputs registered.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
            r_vga_addr_v <= 1'b0;
            r_vga_read_v <= 1'b0;
            r_clear_done <= 1'b0;
            r_ready      <= 1'b1;
            r_luma       <= '0;
            r_in_brush   <= 1'b0;
            r_cross      <= 1'b0;
        end else begin
            r_we         <= 1'b0;
            r_vga_addr_v <= 1'b0;
            r_vga_read_v <= 1'b0;
            r_clear_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.clear_in) begin
                        r_state <= ST_CLEAR;
                        r_addr  <= '0;
                        r_wdata <= 8'h00;
                        r_we    <= 1'b1;
                        r_ready <= 1'b0;
                    end else if (w_accept) begin
                        r_state    <= ST_READ;
                        r_addr     <= w_pix_addr;
                        r_luma     <= bus.y_pixel;
                        r_in_brush <= w_in_brush;
                        r_cross    <= w_cross;
                        r_ready    <= 1'b0;
                    end
                end
                ST_READ:   r_state <= ST_WAIT;
                ST_WAIT:   r_state <= ST_DECIDE;
                ST_DECIDE: begin
                    r_state <= ST_WRITE;
                    r_we    <= w_do_write;
                    r_wdata <= w_wdata;
                end
                ST_WRITE: begin
                    r_state      <= ST_VGA_ADDR;
                    r_vga_addr_v <= 1'b1;
                end
                ST_VGA_ADDR: r_state <= ST_VGA_GAP;
                ST_VGA_GAP: begin
                    r_state      <= ST_VGA_READ;
                    r_vga_read_v <= 1'b1;
                end
                ST_VGA_READ: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
                ST_CLEAR: begin
                    if (r_addr == LP_LAST) begin
                        r_state      <= ST_IDLE;
                        r_clear_done <= 1'b1;
                        r_ready      <= 1'b1;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                        r_we   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.pixel_ready_out        = r_ready;
    assign bus.pixel_addr_forbram     = r_addr;
    assign bus.pixel_for_bram         = r_wdata;
    assign bus.valid_pixel_forbram    = r_we;
    assign bus.pixeladdr_forvga_valid = r_vga_addr_v;
    assign bus.pixelread_forvga_valid = r_vga_read_v;
    assign bus.clear_done_out         = r_clear_done;

endmodule

// File: doc/stroke_painter.md
# stroke_painter

Parametrised successor to the lightboard pixel comparator. It takes the centre-of-mass (COM) pen position and the camera pixel stream, and does a read-modify-write of each frame-buffer pixel. Pixels under a clamped square brush are painted or erased, and the camera luma, threshold mark and crosshair are written elsewhere. It also adds a full-frame clear sweep, an explicit pixel handshake, and brush gating until the first COM arrives. It sits between the COM/filter stage and the frame BRAM, and paces the VGA read of the same address.

## Interface
- `H_PIX`, 320, frame width in pixels
- `V_PIX`, 240, frame height in pixels
- `BRUSH_R`, 1, brush half-size; footprint is (2·BRUSH_R+1)² pixels, clamped at frame edges
- `ADDR_W`, 17, BRAM address width; must satisfy 2^ADDR_W ≥ H_PIX·V_PIX
- `clk_in` in 1: single clock
- `rst_in` in 1: asynchronous, active-high reset
- `x_com_in` in 11, `y_com_in` in 10: COM position
- `com_valid_in` in 1: COM strobe
- `hcount` in 11, `vcount` in 10: incoming pixel coordinates
- `pixel_valid_in` in 1: pixel strobe
- `pixel_ready_out` out 1: high only in IDLE
- `y_pixel` in 6: luma
- `threshold_in` in 1: pixel passed colour threshold
- `color_select` in 2: ink colour
- `write_erase_select` in 1: 0 = write, 1 = erase
- `clear_in` in 1: start clear sweep
- `pixel_from_bram` in 8: BRAM read data, 2-cycle latency
- `pixel_addr_forbram` out ADDR_W: BRAM address
- `pixel_for_bram` out 8: write data
- `valid_pixel_forbram` out 1: write enable
- `pixeladdr_forvga_valid` out 1: VGA may issue its address
- `pixelread_forvga_valid` out 1: VGA read data ready
- `clear_done_out` out 1: one-cycle pulse at end of sweep

## Operation
- Pixel tags (bits [7:6]):
  - 11 = ink, where [1:0] = colour: YELLOW 0xC0, PINK 0xC1, GREEN 0xC2, RED 0xC3
  - 10 = threshold pixel, 0x80
  - 01 = crosshair pixel, 0x40
  - 00 = luma pixel, {2'b00, y_pixel}
- Brush window:
  - On `com_valid_in` with x<H_PIX and y<V_PIX, register the clamped bounds x_lo=max(x−R,0), x_hi=min(x+R,H_PIX−1), and y_lo, y_hi likewise.
  - An out-of-frame COM is ignored and the previous bounds are kept.
  - The `brush_armed` flag is cleared by reset and set by the first accepted COM. Until it is set, no pixel is in the brush.
- States: IDLE → READ → WAIT → DECIDE → WRITE → VGA_ADDR → VGA_GAP → VGA_READ → IDLE, plus CLEAR.
- IDLE, pixel path:
  - Accept when `pixel_valid_in`, hcount<H_PIX and vcount<V_PIX.
  - On accept, latch luma, coordinates, in-brush flag and crosshair flag (hcount==x_com_in or vcount==y_com_in).
  - Drive `pixel_addr_forbram` = vcount·H_PIX + hcount, computed at full ADDR_W width.
  - An out-of-range pixel is dropped with no activity.
- IDLE, clear path: `clear_in` enters CLEAR and takes priority over a simultaneous pixel.
- DECIDE, write mode:
  - Tag 11: no write.
  - Otherwise, in brush: write the colour selected by `color_select`.
  - Otherwise: write threshold if `threshold_in`, else crosshair if the crosshair flag is set, else luma.
- DECIDE, erase mode:
  - Tag 11 and in brush: write luma.
  - Tag 11 and not in brush: no write.
  - Otherwise: write luma.
- CLEAR:
  - Address runs 0 … H_PIX·V_PIX−1, one per cycle, with data 0x00 and write enable high every cycle.
  - `pixel_ready_out` stays low; `clear_in` is ignored during the sweep.
  - After the last address, pulse `clear_done_out` and return to IDLE.

## Timing
- Reset values: state IDLE, `brush_armed` 0, bounds 0, and every output 0 except `pixel_ready_out`, which is 1.
- Cycle 0 is the accept edge. Then:
  - Cycle 1: address valid; it is held through VGA_READ.
  - Cycle 3: DECIDE samples `pixel_from_bram`.
  - Cycle 4: `valid_pixel_forbram` pulses for one cycle, if a write is needed.
  - Cycle 5: `pixeladdr_forvga_valid` pulses for one cycle.
  - Cycle 7: `pixelread_forvga_valid` pulses for one cycle.
  - Cycle 8: back in IDLE. Throughput is one pixel per 8 cycles.
- COM updates during a pixel do not affect it: the brush flag is sampled at accept. A COM strobe on the accept cycle updates the bounds only for the next pixel.
- `rst_in` mid-sweep or mid-pixel aborts immediately with no further writes.

## Configuration
- `STROKE_CROSSHAIR_EN` defined: crosshair overlay behaves as in Operation.
- Undefined: the crosshair flag is tied to 0, so 0x40 is never written. The comparison logic is removed.

## Structure
- `lightboard_pkg` holds:
  - colour, threshold and crosshair constants;
  - the tag field enum;
  - the state enum;
  - the default frame dimensions.
- Sub-module `brush_window` registers the clamped bounds and `brush_armed`, and outputs the combinational in-window test for (hcount, vcount).

## Test plan
- **No COM yet.** Reset, send pixel (0,0) with luma 0x15 and no COM → write 0x15 at address 0; no ink.
- **Paint at corner.** COM (0,0), R=1, yellow, write mode; pixels (1,1) and (2,0) → 0xC0 at address 321; luma at address 2.
- **Erase.** BRAM returns 0xC3 at address 642, COM (2,2), erase mode → luma written; same read with COM (50,50) → no write.
- **Ink protection.** Write mode, BRAM returns 0xC1 outside brush, `threshold_in`=1 → `valid_pixel_forbram` stays 0.
- **Clear sweep.** `clear_in` → 76800 consecutive writes of 0x00 at addresses 0…76799, then `clear_done_out`; `pixel_ready_out` low throughout.
- **Handshake and abort.** Check the VGA strobes land at cycles 5 and 7. Assert `rst_in` at cycle 2 → no write and all outputs return to their reset values.
